// File: rtl/bank_register_if.sv
// Bundle of every signal that crosses the register-file boundary:
// - the WB write port and halt flag;
// - the two ID read ports;
// - the debug dump handshake.
// Signal names are taken from the register file's point of view
// (i_* drives into it, o_* comes out of it).
// - slave modport: used by the register file.
// - master modport: used by the surrounding pipeline and debug unit.
interface bank_register_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
);
  logic               i_WB_reg_write;
  logic [NB_REG-1:0]  i_WB_selected_reg;
  logic [NB_DATA-1:0] i_WB_selected_data;
  logic               i_WB_hlt;
  logic [NB_REG-1:0]  i_ID_rs_addr;
  logic [NB_REG-1:0]  i_ID_rt_addr;
  logic [NB_DATA-1:0] o_ID_rs_data;
  logic [NB_DATA-1:0] o_ID_rt_data;
  logic               o_dump_valid;
  logic [NB_REG-1:0]  o_dump_addr;
  logic [NB_DATA-1:0] o_dump_data;
  logic               i_dump_ready;
  logic               o_dump_done;

  modport slave (
    input  i_WB_reg_write, i_WB_selected_reg, i_WB_selected_data, i_WB_hlt,
    input  i_ID_rs_addr, i_ID_rt_addr, i_dump_ready,
    output o_ID_rs_data, o_ID_rt_data,
    output o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
  );

  modport master (
    output i_WB_reg_write, i_WB_selected_reg, i_WB_selected_data, i_WB_hlt,
    output i_ID_rs_addr, i_ID_rt_addr, i_dump_ready,
    input  o_ID_rs_data, o_ID_rt_data,
    input  o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
  );
endinterface

// File: rtl/bank_register.sv
// General-purpose register file for the ID stage.
// - Commits the WB write and serves the rs/rt read ports combinationally.
// - On halt, streams every register to the debug unit over valid/ready,
//   then parks in DONE until reset.
// Optional feature, selected by the macro BANK_REG_BYPASS_EN:
// - Defined: an IDLE-state write is forwarded to a same-cycle read of the
//   same nonzero index.
// - Undefined: reads see only the stored contents.
module bank_register #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic            i_clock,
  input  logic            i_reset,
  bank_register_if.slave  bus
);

  localparam int              NUM_REGS = 2 ** NB_REG;
  localparam logic [NB_REG-1:0] CNT_ONE  = {{(NB_REG-1){1'b0}}, 1'b1};
  localparam logic [NB_REG-1:0] CNT_LAST = {NB_REG{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP,
    ST_DONE
  } state_t;

  state_t             state, state_next;
  logic [NB_REG-1:0]  dump_cnt, dump_cnt_next;
  logic [NB_DATA-1:0] regs [NUM_REGS];

  // Read helper: index 0 is hard-wired to zero. Optionally, a write in
  // flight in IDLE is forwarded to the reader.
  function automatic logic [NB_DATA-1:0] read_port(input logic [NB_REG-1:0] addr);
    logic [NB_DATA-1:0] value;
    if (addr == '0) begin
      value = '0;
    end else begin
      value = regs[addr];
`ifdef BANK_REG_BYPASS_EN
      if (state == ST_IDLE && bus.i_WB_reg_write && addr == bus.i_WB_selected_reg)
        value = bus.i_WB_selected_data;
`endif
    end
    return value;
  endfunction

  // Register storage: commit WB writes while IDLE. Index 0 is never written.
  // NOTE: the array is built from flops rather than RAM, so it can and must
  // be cleared by reset. A RAM macro would not support this.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == ST_IDLE && bus.i_WB_reg_write &&
                 bus.i_WB_selected_reg != '0) begin
      // NOTE: sequential state uses non-blocking assignment. All flops
      // therefore sample pre-edge values and do not race each other.
      regs[bus.i_WB_selected_reg] <= bus.i_WB_selected_data;
    end
  end

  // Combinational read ports.
  always_comb begin
    bus.o_ID_rs_data = read_port(bus.i_ID_rs_addr);
    bus.o_ID_rt_data = read_port(bus.i_ID_rt_addr);
  end

  // FSM state and dump-counter registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      dump_cnt <= '0;
    end else begin
      state    <= state_next;
      dump_cnt <= dump_cnt_next;
    end
  end

  // FSM next state and dump handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case statement, so no
    // path can leave a variable unassigned and infer a latch.
    state_next       = state;
    dump_cnt_next    = dump_cnt;
    bus.o_dump_valid = 1'b0;
    bus.o_dump_done  = 1'b0;
    bus.o_dump_addr  = '0;
    bus.o_dump_data  = '0;
    case (state)
      ST_IDLE: begin
        if (bus.i_WB_hlt) begin
          state_next    = ST_DUMP;
          dump_cnt_next = '0;
        end
      end
      ST_DUMP: begin
        bus.o_dump_valid = 1'b1;
        bus.o_dump_addr  = dump_cnt;
        bus.o_dump_data  = (dump_cnt == '0) ? '0 : regs[dump_cnt];
        if (bus.i_dump_ready) begin
          if (dump_cnt == CNT_LAST) state_next    = ST_DONE;
          else                      dump_cnt_next = dump_cnt + CNT_ONE;
        end
      end
      ST_DONE: begin
        bus.o_dump_done = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bank_register.sv
// Directed testbench for bank_register.
// - Inputs change on the falling edge.
// - Outputs are sampled 1 ns after the falling edge, away from the rising
//   edge the design uses.
module tb_bank_register;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bank_register_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) bus ();

  bank_register #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected dump contents after the load phase:
  // - r0 reads 0;
  // - r31 holds the value written on the halt edge;
  // - every other rN holds N*4.
  function automatic logic [31:0] exp_beat(input int i);
    if (i == 0)  return 32'h0;
    if (i == 31) return 32'hFFFF_FFFF;
    return 32'(i * 4);
  endfunction

  task automatic check_dump_idle(input string tag, input logic done);
    check({tag, "_valid"}, 32'(bus.o_dump_valid), 32'h0);
    check({tag, "_done"},  32'(bus.o_dump_done),  32'(done));
    check({tag, "_addr"},  32'(bus.o_dump_addr),  32'h0);
    check({tag, "_data"},  bus.o_dump_data,       32'h0);
  endtask

  task automatic check_beat(input string tag, input int i);
    check({tag, "_valid"}, 32'(bus.o_dump_valid), 32'h1);
    check({tag, "_addr"},  32'(bus.o_dump_addr),  32'(i));
    check({tag, "_data"},  bus.o_dump_data,       exp_beat(i));
  endtask

  initial begin
    // Reset state
    rst                    = 1'b1;
    bus.i_WB_reg_write     = 1'b0;
    bus.i_WB_selected_reg  = '0;
    bus.i_WB_selected_data = '0;
    bus.i_WB_hlt           = 1'b0;
    bus.i_ID_rs_addr       = 5'd5;
    bus.i_ID_rt_addr       = 5'd0;
    bus.i_dump_ready       = 1'b0;
    #1;
    check_dump_idle("reset", 1'b0);
    check("reset_rs", bus.o_ID_rs_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write r5, then attempt a write to r0
    bus.i_WB_reg_write     = 1'b1;
    bus.i_WB_selected_reg  = 5'd5;
    bus.i_WB_selected_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.i_WB_selected_reg  = 5'd0;
    bus.i_WB_selected_data = 32'h1234_5678;
    #1;
    check("r0_write_inflight_rt", bus.o_ID_rt_data, 32'h0);
    @(negedge clk);
    bus.i_WB_reg_write = 1'b0;
    #1;
    check("r5_read_rs", bus.o_ID_rs_data, 32'hDEAD_BEEF);
    check("r0_read_rt", bus.o_ID_rt_data, 32'h0);

    // Same-cycle write/read of r7 on both ports
    @(negedge clk);
    bus.i_WB_reg_write     = 1'b1;
    bus.i_WB_selected_reg  = 5'd7;
    bus.i_WB_selected_data = 32'hA5A5_A5A5;
    bus.i_ID_rs_addr       = 5'd7;
    bus.i_ID_rt_addr       = 5'd7;
    #1;
`ifdef BANK_REG_BYPASS_EN
    check("bypass_rs", bus.o_ID_rs_data, 32'hA5A5_A5A5);
    check("bypass_rt", bus.o_ID_rt_data, 32'hA5A5_A5A5);
`else
    check("nobypass_rs", bus.o_ID_rs_data, 32'h0);
    check("nobypass_rt", bus.o_ID_rt_data, 32'h0);
`endif
    @(negedge clk);
    bus.i_WB_reg_write = 1'b0;
    #1;
    check("r7_next_rs", bus.o_ID_rs_data, 32'hA5A5_A5A5);
    check("r7_next_rt", bus.o_ID_rt_data, 32'hA5A5_A5A5);

    // Load rN = N*4 for N = 1..31
    for (int n = 1; n < 32; n++) begin
      @(negedge clk);
      bus.i_WB_reg_write     = 1'b1;
      bus.i_WB_selected_reg  = 5'(n);
      bus.i_WB_selected_data = 32'(n * 4);
    end

    // Halt together with a write r31 = FFFFFFFF; ready held high
    @(negedge clk);
    bus.i_WB_selected_reg  = 5'd31;
    bus.i_WB_selected_data = 32'hFFFF_FFFF;
    bus.i_WB_hlt           = 1'b1;
    bus.i_dump_ready       = 1'b1;
    #1;
    check_dump_idle("pre_halt", 1'b0);

    // 32 dump beats, with ready toggled 1,0,0,1 around beat 4.
    // A write to r3 stays asserted throughout and must be ignored.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.i_WB_hlt           = 1'b0;
        bus.i_WB_selected_reg  = 5'd3;
        bus.i_WB_selected_data = 32'h55;
      end
      if (i == 4) begin
        bus.i_dump_ready = 1'b0;
        #1;
        check_beat("hold0", 4);
        @(negedge clk);
        #1;
        check_beat("hold1", 4);
        bus.i_dump_ready = 1'b1;
      end
      #1;
      check_beat("beat", i);
    end

    // DONE: sticky, valid dropped; halt and the write are ignored
    @(negedge clk);
    bus.i_WB_hlt     = 1'b1;
    bus.i_ID_rs_addr = 5'd3;
    bus.i_ID_rt_addr = 5'd31;
    #1;
    check_dump_idle("done0", 1'b1);
    check("done_r3_no_bypass", bus.o_ID_rs_data, 32'd12);
    check("done_r31",          bus.o_ID_rt_data, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    check_dump_idle("done1", 1'b1);
    check("done_r3_kept", bus.o_ID_rs_data, 32'd12);

    // Reset, then start a fresh dump and reset again at beat 10
    @(negedge clk);
    bus.i_WB_reg_write = 1'b0;
    bus.i_WB_hlt       = 1'b0;
    rst                = 1'b1;
    #1;
    check("rst_r3", bus.o_ID_rs_data, 32'h0);
    check_dump_idle("rst_done", 1'b0);
    @(negedge clk);
    rst          = 1'b0;
    bus.i_WB_hlt = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      bus.i_WB_hlt = 1'b0;
      #1;
      check("redump_valid", 32'(bus.o_dump_valid), 32'h1);
      check("redump_addr",  32'(bus.o_dump_addr),  32'(i));
      check("redump_data",  bus.o_dump_data,       32'h0);
    end
    #1;
    rst = 1'b1;
    #1;
    check_dump_idle("mid_rst", 1'b0);
    bus.i_ID_rs_addr = 5'd10;
    #1;
    check("mid_rst_r10", bus.o_ID_rs_data, 32'h0);

    // A new halt restarts the dump from addr 0
    @(negedge clk);
    rst          = 1'b0;
    bus.i_WB_hlt = 1'b1;
    @(negedge clk);
    bus.i_WB_hlt = 1'b0;
    #1;
    check("restart_valid", 32'(bus.o_dump_valid), 32'h1);
    check("restart_addr0", 32'(bus.o_dump_addr),  32'h0);
    @(negedge clk);
    #1;
    check("restart_addr1", 32'(bus.o_dump_addr),  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
